shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-pass shift unit wrapped around the team's 32-bit combinational `leftshifter`, sitting directly upstream of it in the ALU datapath. It accepts a shift request over a valid/ready handshake and latches the operands. It then drives the single shared `leftshifter` for one or two passes, using bit-reversal wiring to derive logical-right, arithmetic-right and (optionally) rotate results. The final result is held on a valid/ready output until consumed.

## Interface
- Parameters: none; the datapath is fixed at 32 bits and the shift amount at 5 bits to match `leftshifter`.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a request is present.
- `in_ready` out 1: the block can accept a request; high only in IDLE.
- `in_data` in 32: operand.
- `in_amt` in 5: shift amount, 0–31.
- `in_op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `out_valid` out 1: result is valid; held until `out_ready`.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out 32: result.
- `out_err` out 1: unsupported op; qualified by `out_valid`.
- `busy` out 1: state is not IDLE.

## Operation
- Notation: `rev(x)` is 32-bit bit reversal (pure wiring). `shl(x,k)` is the `leftshifter` output.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch `in_data`, `in_amt` and `in_op`, then go to PASS1.
- PASS1: the shifter is driven from the latched registers. The result is captured into `acc` at the end of the cycle.
  - SLL: `acc = shl(d,k)`, then DONE.
  - SRL: `acc = rev(shl(rev(d),k))`, then DONE.
  - SRA: `acc = rev(shl(rev(d),k))`, then PASS2.
  - ROL: `acc = shl(d,k)`, then PASS2.
- PASS2:
  - SRA: `mask = rev(shl(32'hFFFF_FFFF,k))`. Result is `acc | (d[31] ? ~mask : 0)`.
  - ROL: result is `acc | rev(shl(rev(d),(32-k) mod 32))`.
  - Then go to DONE.
- When k=0:
  - Every op returns `d` unchanged.
  - ROL pass 2 uses amount 0 and ORs `d` with `d`.
- DONE: `out_valid`=1 and `out_data`/`out_err` stay stable. When `out_ready`=1, go to IDLE. No new request is accepted in the same cycle.
- Unsupported op (ROL with the rotate feature compiled out):
  - Single pass with no shifter use.
  - `out_data`=0 and `out_err`=1.
- `in_data`, `in_amt` and `in_op` are ignored outside IDLE.

## Timing
- Reset values: `in_ready`=0 while `reset_n`=0, then 1 once in IDLE. `out_valid`=0, `out_data`=0, `out_err`=0, `busy`=0, state IDLE.
- Latency, counting from the accept edge E:
  - SLL, SRL and unsupported op: `out_valid` high after edge E+1.
  - SRA and ROL: `out_valid` high after edge E+2.
- Maximum throughput is one request per 3 cycles (1-pass op) or 4 cycles (2-pass op) with `out_ready` held high.
- Backpressure is unbounded. Outputs are frozen while `out_valid & ~out_ready`.
- Reset asserted in any state:
  - Immediately forces the reset values and discards the in-flight request.
  - First accept is possible on the first edge after deassertion.
- `out_valid` never depends combinationally on `out_ready`, and `in_ready` never depends combinationally on `in_valid`.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined: op 11 performs ROL as above, with two passes.
- Undefined:
  - The PASS2 ROL path and the `(32-k)` subtractor are removed.
  - Op 11 completes in 1 pass with `out_data`=0 and `out_err`=1.
  - SLL, SRL and SRA are unaffected.

## Structure
- Shared package `shift_pkg`:
  - Op encodings `SHIFT_OP_SLL/SRL/SRA/ROL`.
  - State enum `shift_seq_state_t`.
  - Constants `SHIFT_W`=32 and `SHIFT_AMT_W`=5.
- Exactly one sub-module: a single `leftshifter` instance. Its input and amount are muxed per state.
- The bit-reversal function lives in `shift_pkg`.

## Test plan
- SLL `0x0000_0001`, amt 4:
  - `out_data`=`0x0000_0010`.
  - `out_valid` high after edge E+1.
- SRL `0x8000_0000`, amt 31: `out_data`=`0x0000_0001`, `out_err`=0.
- SRA `0x8000_0000`, amt 4: `out_data`=`0xF800_0000`, valid after edge E+2.
- SRA `0x7000_0000`, amt 4: `out_data`=`0x0700_0000`.
- With `SHIFT_SEQ_ROTATE_EN` defined:
  - ROL `0x8000_0001`, amt 1: `0x0000_0003`.
  - ROL `0x1234_5678`, amt 0: `0x1234_5678`.
- With `SHIFT_SEQ_ROTATE_EN` undefined: op 11 gives `out_data`=0 and `out_err`=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles: `out_data` stable, `in_ready`=0.
  - Assert `reset_n`=0 during PASS2: outputs go to 0 immediately.
  - After release, SLL `0x3`, amt 2 returns `0xC`.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-pass shift sequencer around leftshifter.
package shift_pkg;

   localparam int SHIFT_W     = 32;
   localparam int SHIFT_AMT_W = 5;

   typedef enum logic [1:0] {
      SHIFT_OP_SLL = 2'b00,
      SHIFT_OP_SRL = 2'b01,
      SHIFT_OP_SRA = 2'b10,
      SHIFT_OP_ROL = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } shift_seq_state_t;

   // Pure wiring: bit i of the result is bit (W-1-i) of the input.
   function automatic logic [SHIFT_W-1:0] bit_rev(input logic [SHIFT_W-1:0] x);
      for (int i = 0; i < SHIFT_W; i++) begin
         bit_rev[i] = x[SHIFT_W-1-i];
      end
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer; the sequencer is the slave.
interface shift_sequencer_if;
   import shift_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [SHIFT_W-1:0]     in_data;
   logic [SHIFT_AMT_W-1:0] in_amt;
   logic [1:0]             in_op;
   logic                   out_valid;
   logic                   out_ready;
   logic [SHIFT_W-1:0]     out_data;
   logic                   out_err;
   logic                   busy;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_err, busy
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_err, busy
   );

endinterface

// File: rtl/leftshifter.sv
// Shared 32-bit combinational logical left shifter.
module leftshifter
   import shift_pkg::*;
(
   input  logic [SHIFT_W-1:0]     a,
   input  logic [SHIFT_AMT_W-1:0] amt,
   output logic [SHIFT_W-1:0]     y
);

   assign y = a << amt;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: SLL/SRL/SRA (and ROL when SHIFT_SEQ_ROTATE_EN is
// defined) built from one leftshifter plus bit-reversal wiring.
//
// state    | meaning
// ST_IDLE  | ready for a request, operands latched on accept
// ST_PASS1 | first shifter pass, result into acc
// ST_PASS2 | SRA sign fill or ROL wrap-around bits ORed into acc
// ST_DONE  | result held on out_data until out_ready
module shift_sequencer
   import shift_pkg::*;
(
   input  logic           clock,
   input  logic           reset_n,
   shift_sequencer_if.slave bus
);

   shift_seq_state_t       state_q, state_nxt;
   logic [SHIFT_W-1:0]     d_q, acc_q, acc_nxt;
   logic [SHIFT_AMT_W-1:0] k_q;
   shift_op_t              op_q;
   logic                   err_q, err_nxt;
   logic                   accept;
   logic [SHIFT_W-1:0]     sh_in, sh_out;
   logic [SHIFT_AMT_W-1:0] sh_amt;

   leftshifter u_leftshifter (
      .a   (sh_in),
      .amt (sh_amt),
      .y   (sh_out)
   );

   // Shifter operand mux, kept apart from the next-state logic so the
   // shifter output never feeds back into the block that drives its input.
   always_comb begin
      sh_in  = d_q;
      sh_amt = k_q;
      if (state_q == ST_PASS1) begin
         if (op_q == SHIFT_OP_SRL || op_q == SHIFT_OP_SRA) begin
            sh_in = bit_rev(d_q);
         end
`ifndef SHIFT_SEQ_ROTATE_EN
         if (op_q == SHIFT_OP_ROL) begin
            sh_in  = '0;
            sh_amt = '0;
         end
`endif
      end else if (state_q == ST_PASS2) begin
         if (op_q == SHIFT_OP_SRA) begin
            sh_in = '1;
         end
`ifdef SHIFT_SEQ_ROTATE_EN
         if (op_q == SHIFT_OP_ROL) begin
            sh_in  = bit_rev(d_q);
            sh_amt = SHIFT_AMT_W'(SHIFT_W) - k_q;
         end
`endif
      end
   end

   always_comb begin
      state_nxt = state_q;
      acc_nxt   = acc_q;
      err_nxt   = err_q;
      accept    = bus.in_valid & bus.in_ready;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_PASS1;
               err_nxt   = 1'b0;
            end
         end
         ST_PASS1: begin
            unique case (op_q)
               SHIFT_OP_SLL: begin
                  acc_nxt   = sh_out;
                  state_nxt = ST_DONE;
               end
               SHIFT_OP_SRL: begin
                  acc_nxt   = bit_rev(sh_out);
                  state_nxt = ST_DONE;
               end
               SHIFT_OP_SRA: begin
                  acc_nxt   = bit_rev(sh_out);
                  state_nxt = ST_PASS2;
               end
               SHIFT_OP_ROL: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                  acc_nxt   = sh_out;
                  state_nxt = ST_PASS2;
`else
                  acc_nxt   = '0;
                  err_nxt   = 1'b1;
                  state_nxt = ST_DONE;
`endif
               end
               default: state_nxt = ST_DONE;
            endcase
         end
         ST_PASS2: begin
            // sh_out here is the fill mask (SRA) or the wrapped-around bits (ROL).
            if (op_q == SHIFT_OP_SRA) begin
               acc_nxt = acc_q | (d_q[SHIFT_W-1] ? ~bit_rev(sh_out) : '0);
            end else begin
               acc_nxt = acc_q | bit_rev(sh_out);
            end
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         k_q     <= '0;
         op_q    <= SHIFT_OP_SLL;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         acc_q   <= acc_nxt;
         err_q   <= err_nxt;
         if (accept) begin
            d_q  <= bus.in_data;
            k_q  <= bus.in_amt;
            op_q <= shift_op_t'(bus.in_op);
         end
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE) & reset_n;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_data  = acc_q;
   assign bus.out_err   = err_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed and random requests checked
// against an arithmetic reference model; honours SHIFT_SEQ_ROTATE_EN.
module tb_shift_sequencer;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          acc_cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   bit   seen = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] d, input logic [4:0] k, input logic [1:0] op);
      exp_t e;
      e.err     = 1'b0;
      e.lat     = 1;
      e.acc_cyc = 0;
      e.data    = '0;
      case (op)
         2'b00: e.data = d << k;
         2'b01: e.data = d >> k;
         2'b10: begin
            e.data = $signed(d) >>> k;
            e.lat  = 2;
         end
         default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
            e.data = (k == 5'd0) ? d : ((d << k) | (d >> (6'd32 - {1'b0, k})));
            e.lat  = 2;
`else
            e.data = '0;
            e.err  = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   // Caller is in the phase just after a rising edge.
   task automatic send(input logic [31:0] d, input logic [4:0] k, input logic [1:0] op);
      exp_t e;
      bit   ok = 1'b0;
      bus.in_data  = d;
      bus.in_amt   = k;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      e         = model(d, k, op);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_amt   = 5'($urandom);
      bus.in_op    = 2'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         @(posedge clock);
      end
      #1;
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         seen = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares each presented result against the scoreboard front.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               if (!seen) begin
                  check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                  seen = 1'b1;
               end
               if (bus.out_ready) begin
                  check("out_data", bus.out_data, exp_q[0].data);
                  check("out_err", 32'(bus.out_err), 32'(exp_q[0].err));
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      bit   got;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b1;

      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      send(32'h0000_0001, 5'd4, 2'b00);
      send(32'h8000_0000, 5'd31, 2'b01);
      send(32'h8000_0000, 5'd4, 2'b10);
      send(32'h7000_0000, 5'd4, 2'b10);
      send(32'h8000_0001, 5'd1, 2'b11);
      send(32'h1234_5678, 5'd0, 2'b11);
      send(32'hDEAD_BEEF, 5'd0, 2'b10);
      send(32'hFFFF_FFFF, 5'd31, 2'b10);
      drain();

      rdy_mode = 1;
      for (int n = 0; n < 300; n++) begin
         send($urandom, 5'($urandom), 2'($urandom));
      end
      drain();
      rdy_mode = 2;

      // Backpressure: result must stay frozen and no new request accepted.
      @(posedge clock);
      #1;
      send(32'h00FF_00FF, 5'd8, 2'b00);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("bp_valid_seen", 32'(got), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_data_stable", bus.out_data, 32'hFF00_FF00);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      rdy_mode = 0;
      drain();

      // Reset while in PASS2 of an SRA.
      @(posedge clock);
      #1;
      send(32'h8000_0000, 5'd4, 2'b10);
      @(posedge clock);
      #1;
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      seen = 1'b0;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_data", bus.out_data, 32'd0);
      check("midrst_out_err", 32'(bus.out_err), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      send(32'h0000_0003, 5'd2, 2'b00);
      e = model(32'h0000_0003, 5'd2, 2'b00);
      check("post_rst_model", e.data, 32'h0000_000C);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
